split_target_mem: RTL and testbench
===================================

SPLIT_TARGET_MEM -- requirements
Module: split_target_mem

Interface
REQ-001 Parameter INTERNAL_ADDR_BITS, default 12: number of low address bits that index internal memory (2^N bytes).
REQ-002 Parameter READ_LATENCY, default 4: wait cycles between split acknowledge and split request; 0 legal.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 split_grant  input  1  bus grant for returning split read data.
REQ-006 target_addr_in  input  16  transaction address.
REQ-007 target_addr_in_valid  input  1  address strobe, single-cycle.
REQ-008 target_data_in  input  8  write data.
REQ-009 target_data_in_valid  input  1  write data strobe, single-cycle.
REQ-010 target_rw  input  1  1 = write, 0 = read; sampled with target_addr_in_valid.
REQ-011 split_req  output  1  request bus to return read data.
REQ-012 target_data_out  output  8  read data.
REQ-013 target_data_out_valid  output  1  read data strobe.
REQ-014 target_ack  output  1  transaction-complete pulse.
REQ-015 target_split_ack  output  1  read-accepted-and-split pulse.
REQ-016 target_ready  output  1  high only when idle and able to accept an address.

Function
REQ-017 States: IDLE, WR_DATA, WR_ACK, SPLIT_ACK, LATENCY, REQ, SEND.
REQ-018 Memory index = target_addr_in[INTERNAL_ADDR_BITS-1:0]; upper bits ignored (bus decodes).
REQ-019 IDLE, addr_valid, rw=1: latch index; if data_valid same cycle, write and go WR_ACK; else go WR_DATA.
REQ-020 WR_DATA: on data_valid write mem[index] <= target_data_in, go WR_ACK.
REQ-021 WR_ACK: target_ack = 1 for exactly one cycle, return to IDLE; writes never assert target_split_ack.
REQ-022 IDLE, addr_valid, rw=0: latch index, go SPLIT_ACK.
REQ-023 SPLIT_ACK: target_split_ack = 1 for one cycle; go LATENCY, or REQ if READ_LATENCY = 0.
REQ-024 LATENCY: count exactly READ_LATENCY cycles, then go REQ.
REQ-025 REQ: split_req held high until split_grant is sampled high; then go SEND.
REQ-026 SEND: one cycle with target_data_out = mem[index], target_data_out_valid = 1, target_ack = 1; split_req = 0; return to IDLE.
REQ-027 target_data_out holds its last value outside SEND.
REQ-028 target_ready = 1 only in IDLE.
REQ-029 addr_valid or data_valid outside the accepting state is ignored; one outstanding transaction only.
REQ-030 split_grant outside REQ is ignored.
REQ-031 Exactly one target_ack per accepted transaction; exactly one target_split_ack per accepted read.

Reset
REQ-032 Reset forces IDLE and outputs as follows.
  - split_req, target_data_out_valid, target_ack, target_split_ack = 0.
  - target_data_out = 8'h00.
  - target_ready = 1.
  - Latency counter = 0.
REQ-033 Reset mid-transaction abandons it: no ack and no data is produced afterward.
REQ-034 Memory contents are not reset.

Structure
REQ-035 Shared bus package holds ADDR_WIDTH = 16 and DATA_WIDTH = 8; the state enum is local to this module.
REQ-036 Single module, memory inferred inline; no sub-module.

Verification
REQ-037 Write test.
  - Stimulus: IDLE; addr 16'h800A, rw=1, data 8'h5C valid the same cycle.
  - Required: target_ack one cycle after acceptance; target_ready low during the transaction; no target_split_ack.
REQ-038 Split read test.
  - Stimulus: after REQ-037, read 16'h800A; bench drives split_grant the cycle after split_req rises.
  - Required: target_split_ack one cycle after acceptance; split_req rises 4 cycles after the split-ack cycle; one cycle after grant, target_data_out = 8'h5C with data_out_valid and ack.
REQ-039 Delayed grant test.
  - Stimulus: as REQ-038, but grant withheld for 10 cycles.
  - Required: split_req stays high the whole time; data returns one cycle after grant; ack count = 1.
REQ-040 Busy and alias test.
  - Stimulus: new addr_valid during LATENCY; then read 16'hF00A after writing 16'h800A.
  - Required: the busy-time request is ignored, with no extra ack; the read returns the 16'h800A data.
REQ-041 Reset test.
  - Stimulus: assert rst_n low while in REQ.
  - Required: split_req = 0 immediately; target_ready = 1 after release; no ack afterward.

Source files
------------

// File: rtl/split_target_mem_pkg.sv
// split_target_mem_pkg: shared bus widths for targets on the split-transaction bus
package split_target_mem_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 8;
endpackage

// File: rtl/split_target_mem.sv
// split_target_mem: bus target with internal byte memory; writes complete directly, reads are split and returned on grant
module split_target_mem
  import split_target_mem_pkg::*;
#(
  parameter int INTERNAL_ADDR_BITS = 12,
  parameter int READ_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  split_grant,
  input  logic [ADDR_WIDTH-1:0] target_addr_in,
  input  logic                  target_addr_in_valid,
  input  logic [DATA_WIDTH-1:0] target_data_in,
  input  logic                  target_data_in_valid,
  input  logic                  target_rw,
  output logic                  split_req,
  output logic [DATA_WIDTH-1:0] target_data_out,
  output logic                  target_data_out_valid,
  output logic                  target_ack,
  output logic                  target_split_ack,
  output logic                  target_ready
);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_ACK, SPLIT_ACK, LATENCY, REQ, SEND} state_e;
  localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY > 0 ? READ_LATENCY - 1 : 0);
  state_e state_q, state_d;
  logic [INTERNAL_ADDR_BITS-1:0] idx_q, idx_d, mem_waddr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic mem_we;
  logic [DATA_WIDTH-1:0] mem [2**INTERNAL_ADDR_BITS];
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    dout_d = dout_q;
    mem_we = 1'b0;
    mem_waddr = idx_q;
    case (state_q)
      IDLE: if (target_addr_in_valid) begin
        idx_d = target_addr_in[INTERNAL_ADDR_BITS-1:0];
        mem_waddr = target_addr_in[INTERNAL_ADDR_BITS-1:0];
        mem_we = target_rw & target_data_in_valid;
        state_d = !target_rw ? SPLIT_ACK : target_data_in_valid ? WR_ACK : WR_DATA;
      end
      WR_DATA: if (target_data_in_valid) begin
        mem_we = 1'b1;
        state_d = WR_ACK;
      end
      WR_ACK: state_d = IDLE;
      SPLIT_ACK: begin
        cnt_d = '0;
        state_d = READ_LATENCY == 0 ? REQ : LATENCY;
      end
      LATENCY: begin
        cnt_d = cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CNT_LAST ? REQ : LATENCY;
      end
      // capture read data on grant so it holds after the SEND cycle
      REQ: if (split_grant) begin
        dout_d = mem[idx_q];
        state_d = SEND;
      end
      SEND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= target_data_in;
  end
  assign split_req = state_q == REQ;
  assign target_data_out = dout_q;
  assign target_data_out_valid = state_q == SEND;
  assign target_ack = state_q == WR_ACK || state_q == SEND;
  assign target_split_ack = state_q == SPLIT_ACK;
  assign target_ready = state_q == IDLE;
endmodule

// File: tb/tb_split_target_mem.sv
// tb_split_target_mem: table-driven and randomized transaction checks against a byte-array memory model
module tb_split_target_mem;
  localparam int LAT = 4;
  localparam int IAB = 12;
  logic clk = 1'b0, rst_n = 1'b0, split_grant = 1'b0;
  logic [15:0] addr = '0;
  logic av = 1'b0, dv = 1'b0, rw = 1'b0;
  logic [7:0] din = '0;
  logic split_req, dout_valid, ack, split_ack, ready;
  logic [7:0] dout;
  int n_vec = 0, n_err = 0;
  int ack_seen = 0, sack_seen = 0;
  logic [7:0] mdl [2**IAB];
  int written [$];
  typedef struct {
    bit rw;
    logic [15:0] addr;
    logic [7:0] data;
    int gap;
    bit noise;
  } vec_t;
  vec_t tbl [10];
  split_target_mem #(.INTERNAL_ADDR_BITS(IAB), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .split_grant(split_grant),
    .target_addr_in(addr), .target_addr_in_valid(av),
    .target_data_in(din), .target_data_in_valid(dv), .target_rw(rw),
    .split_req(split_req), .target_data_out(dout), .target_data_out_valid(dout_valid),
    .target_ack(ack), .target_split_ack(split_ack), .target_ready(ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ack) ack_seen <= ack_seen + 1;
    if (split_ack) sack_seen <= sack_seen + 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int gap);
    int a0, s0;
    a0 = ack_seen;
    s0 = sack_seen;
    chk("wr_ready_idle", ready, 1);
    addr = a; rw = 1'b1; din = d; av = 1'b1; dv = (gap == 0);
    tick;
    av = 1'b0; dv = 1'b0;
    for (int i = 0; i < gap; i++) begin
      chk("wr_wait_ready", ready, 0);
      chk("wr_wait_ack", ack, 0);
      if (i == gap - 1) dv = 1'b1;
      tick;
      dv = 1'b0;
    end
    chk("wr_ack", ack, 1);
    chk("wr_no_split_ack", split_ack, 0);
    chk("wr_busy", ready, 0);
    tick;
    chk("wr_ack_one_cycle", ack, 0);
    chk("wr_ready_after", ready, 1);
    chk("wr_ack_count", ack_seen - a0, 1);
    chk("wr_sack_count", sack_seen - s0, 0);
    mdl[a[IAB-1:0]] = d;
    written.push_back(int'(a[IAB-1:0]));
  endtask
  task automatic do_read(input logic [15:0] a, input int gd, input bit noise, input logic [7:0] exp);
    int a0, s0;
    a0 = ack_seen;
    s0 = sack_seen;
    chk("rd_ready_idle", ready, 1);
    addr = a; rw = 1'b0; av = 1'b1;
    tick;
    av = 1'b0;
    chk("rd_split_ack", split_ack, 1);
    chk("rd_sack_no_ack", ack, 0);
    chk("rd_busy", ready, 0);
    for (int i = 0; i < LAT; i++) begin
      if (noise) begin
        av = 1'b1; rw = 1'($urandom); dv = 1'b1; split_grant = 1'b1;
        addr = 16'($urandom); din = 8'($urandom);
      end
      tick;
      chk("rd_latency_req", split_req, 0);
      chk("rd_latency_ack", ack | split_ack, 0);
      chk("rd_latency_ready", ready, 0);
    end
    tick;
    av = 1'b0; dv = 1'b0; split_grant = 1'b0;
    for (int j = 0; j < gd; j++) begin
      chk("rd_req_held", split_req, 1);
      chk("rd_req_no_data", dout_valid | ack, 0);
      tick;
    end
    chk("rd_req_high", split_req, 1);
    split_grant = 1'b1;
    tick;
    split_grant = 1'b0;
    chk("rd_data", dout, exp);
    chk("rd_data_valid", dout_valid, 1);
    chk("rd_data_ack", ack, 1);
    chk("rd_req_low_send", split_req, 0);
    tick;
    chk("rd_idle_ready", ready, 1);
    chk("rd_idle_ack", ack | dout_valid, 0);
    chk("rd_data_hold", dout, exp);
    chk("rd_ack_count", ack_seen - a0, 1);
    chk("rd_sack_count", sack_seen - s0, 1);
  endtask
  initial begin
    tbl[0] = '{1'b1, 16'h800A, 8'h5C, 0, 1'b0};
    tbl[1] = '{1'b0, 16'h800A, 8'h5C, 1, 1'b0};
    tbl[2] = '{1'b0, 16'h800A, 8'h5C, 10, 1'b0};
    tbl[3] = '{1'b0, 16'hF00A, 8'h5C, 1, 1'b1};
    tbl[4] = '{1'b1, 16'h0001, 8'hA5, 3, 1'b0};
    tbl[5] = '{1'b0, 16'h4001, 8'hA5, 0, 1'b1};
    tbl[6] = '{1'b1, 16'hFFFF, 8'h3C, 0, 1'b0};
    tbl[7] = '{1'b0, 16'h0FFF, 8'h3C, 2, 1'b0};
    tbl[8] = '{1'b1, 16'h0000, 8'h00, 1, 1'b0};
    tbl[9] = '{1'b0, 16'hA000, 8'h00, 0, 1'b0};
    #12;
    chk("rst_split_req", split_req, 0);
    chk("rst_data_valid", dout_valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_split_ack", split_ack, 0);
    chk("rst_data_out", dout, 8'h00);
    chk("rst_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    for (int k = 0; k < 10; k++) begin
      if (tbl[k].rw) do_write(tbl[k].addr, tbl[k].data, tbl[k].gap);
      else do_read(tbl[k].addr, tbl[k].gap, tbl[k].noise, tbl[k].data);
    end
    do_write(16'h0123, 8'h77, 2);
    addr = 16'h0123; rw = 1'b0; av = 1'b1;
    tick;
    av = 1'b0;
    repeat (LAT + 1) tick;
    chk("rst_test_in_req", split_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_drop", split_req, 0);
    chk("rst_ready_now", ready, 1);
    chk("rst_dout_clear", dout, 8'h00);
    split_grant = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int a0;
      a0 = ack_seen;
      repeat (8) begin
        tick;
        chk("post_rst_quiet", {ack, dout_valid, split_req, split_ack}, 0);
        chk("post_rst_ready", ready, 1);
      end
      chk("post_rst_ack_count", ack_seen - a0, 0);
    end
    split_grant = 1'b0;
    do_read(16'h7123, 2, 1'b0, 8'h77);
    for (int k = 0; k < 30; k++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
        do_write(16'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      end else begin
        int idx;
        logic [15:0] a;
        idx = written[$urandom_range(0, written.size() - 1)];
        a = 16'($urandom);
        a[IAB-1:0] = IAB'(idx);
        do_read(a, int'($urandom_range(0, 5)), 1'($urandom), mdl[idx]);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
